// File: rtl/text_gpu_core.sv
// Character-cell text renderer: cell VRAM + palette + blinking cursor -> 4:4:4 RGB from scan (x,y).
// Latency: pixel path 4 cycles x/y -> r/g/b; bus write acked after 1 cycle, bus read after 2 cycles.
// Backpressure: none on the pixel path; a bus request is held on w_stb until its single-cycle w_ack.
module text_gpu_core #(
    parameter int H_RES        = 800,
    parameter int V_RES        = 480,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int COLS         = 100,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30,
    parameter bit FLIP_V_RST   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   w_addr,
    input  logic [31:0]                   w_dat_i,
    input  logic                          w_we,
    input  logic                          w_stb,
    output logic [31:0]                   w_dat_o,
    output logic                          w_ack,
    input  logic [9:0]                    x,
    input  logic [8:0]                    y,
    output logic [8+$clog2(GLYPH_H)-1:0]  glyph_addr,
    input  logic [GLYPH_W-1:0]            glyph_data,
    output logic [3:0]                    r,
    output logic [3:0]                    g,
    output logic [3:0]                    b,
    output logic [9:0]                    res_x,
    output logic [8:0]                    res_y
);
    localparam int GW_B  = $clog2(GLYPH_W);
    localparam int GH_B  = $clog2(GLYPH_H);
    localparam int CELLS = COLS * ROWS;
    localparam int VA_W  = $clog2(CELLS);
    localparam int BC_W  = $clog2(BLINK_FRAMES) + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;

    // Bus-side state
    logic [1:0]        r_state;
    logic [31:0]       r_dat_o;
    logic              r_rd_vram, r_rd_pal, r_rd_ctrl, r_rd_cur;
    logic [3:0]        r_rd_pidx;
    logic [11:0]       r_pal [16];
    logic              r_flip_v, r_flip_h, r_cur_en;
    logic [6:0]        r_cur_col, r_cur_row;
    logic [BC_W-1:0]   r_blink_cnt;
    logic              r_blink_ph;
    logic              r_prev_origin;

    // Cell memory, not reset
    logic [15:0]       r_vram [CELLS];
    logic [15:0]       r_vram_a_q, r_vram_b_q;

    // Pixel pipeline
    logic              r_s0_vld;
    logic [9:0]        r_s0_rx;
    logic [8:0]        r_s0_ry;
    logic              r_s1_vld;
    logic [6:0]        r_s1_col, r_s1_row;
    logic [GW_B-1:0]   r_s1_off;
    logic [GH_B-1:0]   r_s1_grow;
    logic              r_s2_vld, r_s2_cur;
    logic [GW_B-1:0]   r_s2_off;
    logic [3:0]        r_s2_fg, r_s2_bg;
    logic [8+GH_B-1:0] r_glyph_addr;
    logic [11:0]       r_rgb;

    // Combinational nets
    logic              w_is_vram, w_is_pal, w_is_ctrl, w_is_cur;
    logic              w_bus_wr, w_vram_we, w_blink_arm, w_origin, w_frame_start;
    logic [VA_W-1:0]   w_vaddr_a, w_vaddr_b;
    logic [31:0]       w_rd_mux;
    logic              w_pix_vld;
    logic [9:0]        w_rx;
    logic [8:0]        w_ry;
    logic [31:0]       w_cell_idx;
    logic [GW_B-1:0]   w_bit_idx;
    logic              w_bit, w_inv;
    logic [3:0]        w_pidx;
    logic              w_unused_ok;

    assign w_is_vram     = (w_addr[15] == 1'b0) && (32'(w_addr[14:2]) < 32'(CELLS));
    assign w_is_pal      = (w_addr[15:6] == 10'h200);
    assign w_is_ctrl     = (w_addr[15:2] == 14'h3000);
    assign w_is_cur      = (w_addr[15:2] == 14'h3001);
    assign w_bus_wr      = (r_state == S_IDLE) && w_stb && w_we;
    assign w_vram_we     = w_bus_wr && w_is_vram && rst_n;
    assign w_blink_arm   = w_bus_wr && w_is_ctrl && w_dat_i[2];
    assign w_vaddr_a     = w_is_vram ? w_addr[VA_W+1:2] : '0;
    assign w_origin      = (x == 10'd0) && (y == 9'd0);
    assign w_frame_start = w_origin && !r_prev_origin;
    assign w_unused_ok   = ^{w_dat_i[31:23], w_addr[1:0]};

    // Read data selection, evaluated in RD_WAIT against the decode latched in IDLE
    always_comb begin
        w_rd_mux = '0;
        if (r_rd_vram) begin
            w_rd_mux[15:0] = r_vram_a_q;
        end else if (r_rd_pal) begin
            w_rd_mux[11:0] = r_pal[r_rd_pidx];
        end else if (r_rd_ctrl) begin
            w_rd_mux[2:0] = {r_cur_en, r_flip_h, r_flip_v};
        end else if (r_rd_cur) begin
            w_rd_mux[6:0]   = r_cur_col;
            w_rd_mux[22:16] = r_cur_row;
        end
    end

    // Bus FSM: writes commit on IDLE->ACK, reads pass through RD_WAIT for the memory read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dat_o   <= '0;
            r_rd_vram <= 1'b0;
            r_rd_pal  <= 1'b0;
            r_rd_ctrl <= 1'b0;
            r_rd_cur  <= 1'b0;
            r_rd_pidx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_stb) begin
                        r_state   <= w_we ? S_ACK : S_RD_WAIT;
                        r_rd_vram <= w_is_vram;
                        r_rd_pal  <= w_is_pal;
                        r_rd_ctrl <= w_is_ctrl;
                        r_rd_cur  <= w_is_cur;
                        r_rd_pidx <= w_addr[5:2];
                    end
                end
                S_RD_WAIT: begin
                    r_state <= S_ACK;
                    r_dat_o <= w_rd_mux;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_dat_o <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus-writable palette, flip/cursor controls and cursor position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_pal[i] <= {4'(i), 4'(i), 4'(i)};
            r_flip_v  <= FLIP_V_RST;
            r_flip_h  <= 1'b0;
            r_cur_en  <= 1'b0;
            r_cur_col <= '0;
            r_cur_row <= '0;
        end else if (w_bus_wr) begin
            if (w_is_pal) r_pal[w_addr[5:2]] <= w_dat_i[11:0];
            if (w_is_ctrl) begin
                r_flip_v <= w_dat_i[0];
                r_flip_h <= w_dat_i[1];
                r_cur_en <= w_dat_i[2];
            end
            if (w_is_cur) begin
                r_cur_col <= w_dat_i[6:0];
                r_cur_row <= w_dat_i[22:16];
            end
        end
    end

    // Cursor blink: count frame starts, toggle phase every BLINK_FRAMES; enabling re-arms visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_ph    <= 1'b0;
            r_prev_origin <= 1'b0;
        end else begin
            r_prev_origin <= w_origin;
            if (w_blink_arm) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= 1'b1;
            end else if (w_frame_start) begin
                if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_ph  <= ~r_blink_ph;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // Dual-port cell VRAM: port A bus, port B pixel; read-before-write on collisions
    always_ff @(posedge clk) begin
        if (w_vram_we) r_vram[w_vaddr_a] <= w_dat_i[15:0];
        r_vram_a_q <= r_vram[w_vaddr_a];
        r_vram_b_q <= r_vram[w_vaddr_b];
    end

    assign w_pix_vld  = (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));
    assign w_rx       = r_flip_h ? (10'(H_RES - 1) - x) : x;
    assign w_ry       = r_flip_v ? (9'(V_RES - 1) - y) : y;
    assign w_cell_idx = 32'(r_s0_ry >> GH_B) * 32'(COLS) + 32'(r_s0_rx >> GW_B);
    assign w_vaddr_b  = r_s0_vld ? VA_W'(w_cell_idx) : '0;
    assign w_bit_idx  = GW_B'(GLYPH_W - 1) - r_s2_off;
    assign w_bit      = glyph_data[w_bit_idx];
    assign w_inv      = r_s2_cur && r_cur_en && r_blink_ph;
    assign w_pidx     = (w_bit ^ w_inv) ? r_s2_fg : r_s2_bg;

    // Pixel pipeline S0..S3: flip, cell fetch, glyph address, colour lookup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld     <= 1'b0;
            r_s0_rx      <= '0;
            r_s0_ry      <= '0;
            r_s1_vld     <= 1'b0;
            r_s1_col     <= '0;
            r_s1_row     <= '0;
            r_s1_off     <= '0;
            r_s1_grow    <= '0;
            r_s2_vld     <= 1'b0;
            r_s2_cur     <= 1'b0;
            r_s2_off     <= '0;
            r_s2_fg      <= '0;
            r_s2_bg      <= '0;
            r_glyph_addr <= '0;
            r_rgb        <= '0;
        end else begin
            r_s0_vld     <= w_pix_vld;
            r_s0_rx      <= w_rx;
            r_s0_ry      <= w_ry;
            r_s1_vld     <= r_s0_vld;
            r_s1_col     <= 7'(r_s0_rx >> GW_B);
            r_s1_row     <= 7'(r_s0_ry >> GH_B);
            r_s1_off     <= r_s0_rx[GW_B-1:0];
            r_s1_grow    <= r_s0_ry[GH_B-1:0];
            r_s2_vld     <= r_s1_vld;
            r_s2_cur     <= (r_s1_col == r_cur_col) && (r_s1_row == r_cur_row) &&
                            (32'(r_cur_col) < 32'(COLS)) && (32'(r_cur_row) < 32'(ROWS));
            r_s2_off     <= r_s1_off;
            r_s2_fg      <= r_vram_b_q[11:8];
            r_s2_bg      <= r_vram_b_q[15:12];
            r_glyph_addr <= {r_vram_b_q[7:0], r_s1_grow};
            r_rgb        <= r_s2_vld ? r_pal[w_pidx] : 12'h000;
        end
    end

    assign w_dat_o    = r_dat_o;
    assign w_ack      = (r_state == S_ACK);
    assign glyph_addr = r_glyph_addr;
    assign {r, g, b}  = r_rgb;
    assign res_x      = 10'(H_RES - 1);
    assign res_y      = 9'(V_RES - 1);

endmodule

// File: tb/tb_text_gpu_core.sv
// Bench for text_gpu_core: vector table, bus sequences, cursor blink and async reset,
// plus randomized scans compared against a cell/glyph/palette reference model.
module tb_text_gpu_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] w_addr;
    logic [31:0] w_dat_i, w_dat_o;
    logic        w_we, w_stb, w_ack;
    logic [9:0]  x, res_x;
    logic [8:0]  y, res_y;
    logic [11:0] glyph_addr;
    logic [7:0]  glyph_data;
    logic [3:0]  r, g, b;

    always #5 clk = ~clk;

    logic [7:0] rom [4096];
    assign glyph_data = rom[glyph_addr];

    text_gpu_core dut (
        .clk(clk), .rst_n(rst_n), .w_addr(w_addr), .w_dat_i(w_dat_i), .w_we(w_we),
        .w_stb(w_stb), .w_dat_o(w_dat_o), .w_ack(w_ack), .x(x), .y(y),
        .glyph_addr(glyph_addr), .glyph_data(glyph_data), .r(r), .g(g), .b(b),
        .res_x(res_x), .res_y(res_y)
    );

    // Reference state
    logic [15:0] m_vram [3000];
    logic [11:0] m_pal [16];
    bit          m_fv, m_fh, m_cur_en, m_base_ph;
    int          m_cur_col, m_cur_row, m_frames, cur_px, cur_py;
    int          n_cmp, n_err;

    typedef struct {
        logic [9:0]  vx;
        logic [8:0]  vy;
        logic [1:0]  ctrl;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = {4'(i), 4'(i), 4'(i)};
        m_fv = 1'b1; m_fh = 1'b0; m_cur_en = 1'b0; m_base_ph = 1'b0;
        m_cur_col = 0; m_cur_row = 0; m_frames = 0;
    endfunction

    function automatic logic [11:0] exp_pix(input int px, input int py);
        int rx, ry;
        logic [15:0] c;
        logic [7:0] bits;
        logic [3:0] fg, bg, t;
        bit ph, bv;
        if (px >= 800 || py >= 480) return 12'h000;
        rx = m_fh ? 799 - px : px;
        ry = m_fv ? 479 - py : py;
        c = m_vram[(ry / 16) * 100 + rx / 8];
        bits = rom[int'(c[7:0]) * 16 + ry % 16];
        bv = bits[7 - rx % 8];
        fg = c[11:8];
        bg = c[15:12];
        ph = m_base_ph ^ (((m_frames / 30) % 2) != 0);
        if (m_cur_en && ph && m_cur_col == rx / 8 && m_cur_row == ry / 16) begin
            t = fg; fg = bg; bg = t;
        end
        return bv ? m_pal[fg] : m_pal[bg];
    endfunction

    task automatic set_px(input int px, input int py);
        if (px == 0 && py == 0 && !(cur_px == 0 && cur_py == 0)) m_frames++;
        cur_px = px; cur_py = py;
        x = 10'(px); y = 9'(py);
    endtask

    task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output int lat);
        lat = 0; rdata = '0;
        w_stb = 1'b1; w_we = we; w_addr = addr; w_dat_i = data;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (w_ack) begin lat = i; rdata = w_dat_o; break; end
        end
        w_stb = 1'b0; w_we = 1'b0;
        if (lat == 0) begin
            n_cmp++; n_err++;
            $display("FAIL bus_timeout: addr 0x%0h got no ack, required ack within 8 cycles", addr);
        end else begin
            @(posedge clk); #1;
            check("ack_one_cycle", 32'(w_ack), 32'd0);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        logic [31:0] rd_d;
        int lat, a;
        bus_xfer(1'b1, addr, data, rd_d, lat);
        if (lat != 0) check("wr_latency", lat, 1);
        a = int'(addr) & 32'hFFFC;
        if (a < 32'h8000) begin
            if (a / 4 < 3000) m_vram[a / 4] = data[15:0];
        end else if (a < 32'h8040) begin
            m_pal[(a - 32'h8000) / 4] = data[11:0];
        end else if (a == 32'hC000) begin
            m_fv = data[0]; m_fh = data[1]; m_cur_en = data[2];
            if (data[2]) begin m_frames = 0; m_base_ph = 1'b1; end
        end else if (a == 32'hC004) begin
            m_cur_col = int'(data[6:0]); m_cur_row = int'(data[22:16]);
        end
    endtask

    task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd_d;
        int lat;
        bus_xfer(1'b0, addr, 32'hDEAD_BEEF, rd_d, lat);
        if (lat != 0) begin
            check({name, "_latency"}, lat, 2);
            check(name, rd_d, exp);
        end
    endtask

    task automatic px_check(input int px, input int py, input logic [11:0] exp, input string name);
        set_px(px, py);
        repeat (4) begin @(posedge clk); #1; end
        check(name, {20'd0, r, g, b}, {20'd0, exp});
    endtask

    task automatic pulse_frames(input int n);
        repeat (n) begin
            set_px(0, 0); @(posedge clk); #1;
            set_px(1, 0); @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [11:0] expq[$];
        int px, py;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; x = 10'd1; y = 9'd0; cur_px = 1; cur_py = 0;
        w_stb = 1'b0; w_we = 1'b0; w_addr = '0; w_dat_i = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h410] = 8'h80;
        model_reset();

        vecs[0] = '{10'd0,    9'd0,   2'd0, 12'hFFF};
        vecs[1] = '{10'd1,    9'd0,   2'd0, 12'h000};
        vecs[2] = '{10'd7,    9'd0,   2'd0, 12'h000};
        vecs[3] = '{10'd800,  9'd0,   2'd0, 12'h000};
        vecs[4] = '{10'd0,    9'd480, 2'd0, 12'h000};
        vecs[5] = '{10'd799,  9'd479, 2'd3, 12'hFFF};
        vecs[6] = '{10'd798,  9'd479, 2'd3, 12'h000};
        vecs[7] = '{10'd0,    9'd479, 2'd1, 12'hFFF};
        vecs[8] = '{10'd799,  9'd0,   2'd2, 12'hFFF};
        vecs[9] = '{10'd1023, 9'd511, 2'd3, 12'h000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", {20'd0, r, g, b}, 32'd0);
        check("rst_ack", 32'(w_ack), 32'd0);
        check("rst_dat_o", w_dat_o, 32'd0);
        check("rst_glyph_addr", 32'(glyph_addr), 32'd0);
        check("res_x", 32'(res_x), 32'd799);
        check("res_y", 32'(res_y), 32'd479);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(16'hC000, 32'h1, "rst_ctrl");
        rd(16'h8014, 32'h555, "rst_pal5");
        rd(16'hC004, 32'h0, "rst_cursor");

        // Fill VRAM and palette, then the known scene
        for (int n = 0; n < 3000; n++) wr(16'(4 * n), $urandom);
        for (int i = 0; i < 16; i++) wr(16'(32'h8000 + 4 * i), $urandom);
        wr(16'h0000, 32'h0F41);
        wr(16'h803C, 32'hFFF);
        wr(16'h8000, 32'h000);

        // Glyph address at S2 for (0,0) unflipped
        wr(16'hC000, 32'h0);
        set_px(0, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("glyph_addr_A", 32'(glyph_addr), 32'h410);
        @(posedge clk); #1;
        check("px00_rgb", {20'd0, r, g, b}, 32'hFFF);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            wr(16'hC000, 32'(vecs[i].ctrl));
            px_check(int'(vecs[i].vx), int'(vecs[i].vy), vecs[i].exp, $sformatf("vec%0d_rgb", i));
        end

        // Bus read-back and decode corners
        wr(16'h0004, 32'h1234);
        rd(16'h0004, 32'h0000_1234, "rd_cell1");
        rd(16'h0007, 32'h0000_1234, "rd_cell1_bytebits");
        wr(16'h0008, 32'hFFFF_5A5A);
        rd(16'h0008, 32'h0000_5A5A, "rd_cell2_upper");
        rd(16'hF000, 32'h0, "rd_unmapped");
        wr(16'h2EE0, 32'hBEEF);
        rd(16'h2EE0, 32'h0, "rd_cell_oob");
        rd(16'h803C, 32'hFFF, "rd_pal15");
        wr(16'hC004, 32'h001D_0063);
        rd(16'hC004, 32'h001D_0063, "rd_cursor");
        wr(16'hC000, 32'h3);
        rd(16'hC000, 32'h3, "rd_ctrl");

        // Randomized pipelined scans under each flip setting
        for (int f = 0; f < 4; f++) begin
            wr(16'hC000, 32'(f));
            for (int c = 0; c < 103; c++) begin
                if (c < 100) begin
                    px = $urandom_range(0, 850);
                    py = $urandom_range(0, 500);
                    expq.push_back(exp_pix(px, py));
                    set_px(px, py);
                end
                @(posedge clk); #1;
                if (c >= 3) check("rand_px", {20'd0, r, g, b}, {20'd0, expq.pop_front()});
            end
        end

        // Cursor blink on cell 0
        wr(16'hC000, 32'h0);
        set_px(1, 0);
        wr(16'hC004, 32'h0);
        wr(16'hC000, 32'h4);
        px_check(1, 0, 12'hFFF, "cur_inv_start");
        pulse_frames(29);
        px_check(1, 0, 12'hFFF, "cur_inv_29");
        pulse_frames(1);
        px_check(1, 0, 12'h000, "cur_normal_30");
        pulse_frames(30);
        px_check(1, 0, 12'hFFF, "cur_inv_60");

        // Cursor on another cell, checked against the model
        wr(16'hC004, 32'h0002_0005);
        for (int i = 0; i < 6; i++) begin
            px = 40 + $urandom_range(0, 7);
            py = 32 + $urandom_range(0, 15);
            px_check(px, py, exp_pix(px, py), "cur_cell205");
        end

        // Cursor column off-screen: nothing inverted
        wr(16'hC004, 32'h0000_0064);
        px_check(1, 0, 12'h000, "cur_oob_cell0");
        for (int i = 0; i < 4; i++) begin
            px = 792 + $urandom_range(0, 7);
            py = $urandom_range(0, 15);
            px_check(px, py, exp_pix(px, py), "cur_oob_cell99");
        end

        // Async reset in the middle of a read
        px_check(0, 0, 12'hFFF, "pre_rst_px");
        w_stb = 1'b1; w_we = 1'b0; w_addr = 16'h0004;
        @(posedge clk); #1;
        check("rdwait_no_ack", 32'(w_ack), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(w_ack), 32'd0);
        check("arst_rgb", {20'd0, r, g, b}, 32'd0);
        check("arst_dat_o", w_dat_o, 32'd0);
        check("arst_glyph_addr", 32'(glyph_addr), 32'd0);
        w_stb = 1'b0;
        repeat (3) begin @(posedge clk); #1; check("arst_hold_ack", 32'(w_ack), 32'd0); end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; check("arst_post_ack", 32'(w_ack), 32'd0); end
        model_reset();
        rd(16'hC000, 32'h1, "post_rst_ctrl");
        rd(16'h8014, 32'h555, "post_rst_pal5");
        rd(16'hC004, 32'h0, "post_rst_cursor");
        rd(16'h0004, 32'h1234, "post_rst_vram_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/text_gpu_core.md
Name: text_gpu_core

Overview:
Parametrised character-cell text renderer, successor to the monochrome GPU core. Converts monitor scan coordinates (x,y) into 4:4:4 RGB pixels using:
- an internal dual-port cell VRAM (char code plus fg/bg colour index per cell)
- an external charset ROM
- a bus-writable 16-entry palette
- configurable flips and a blinking cursor
It sits between the bus fabric and the display timing generator.

Parameters:
H_RES, 800, active width in pixels; drives res_x = H_RES-1
V_RES, 480, active height in pixels; drives res_y = V_RES-1
GLYPH_W, 8, glyph width in pixels; power of two, max 16
GLYPH_H, 16, glyph height in rows; power of two
COLS, 100, text columns (H_RES/GLYPH_W)
ROWS, 30, text rows (V_RES/GLYPH_H)
BLINK_FRAMES, 30, frames per cursor blink phase
FLIP_V_RST, 1, reset value of vertical-flip control bit

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  asynchronous active-low reset
w_addr  in  16  bus byte address
w_dat_i  in  32  bus write data
w_we  in  1  1=write, 0=read
w_stb  in  1  request; held until w_ack
w_dat_o  out  32  read data, valid with w_ack
w_ack  out  1  single-cycle acknowledge
x  in  10  scan column
y  in  9  scan row
glyph_addr  out  8+log2(GLYPH_H)  {char_code, glyph_row} to charset ROM
glyph_data  in  GLYPH_W  ROM row bits, valid 1 cycle after glyph_addr; MSB = leftmost pixel
r, g, b  out  4 each  pixel colour
res_x  out  10  H_RES-1 constant
res_y  out  9  V_RES-1 constant

Behaviour:
- Reset values: r/g/b=0, w_ack=0, w_dat_o=0, glyph_addr=0, flip_v=FLIP_V_RST, flip_h=0, cursor_en=0, cursor_col=cursor_row=0, blink phase=0, blink counter=0. Palette[i] resets to {i,i,i} (grey ramp). VRAM contents are not reset.
- Address map (word aligned; byte bits [1:0] ignored):
  - 0x0000+4n: VRAM cell n, n < COLS*ROWS. Data [15:0] = {bg[15:12], fg[11:8], char[7:0]}; upper bits read 0.
  - 0x8000+4i: palette i, i = 0..15. Data [11:0] = {R,G,B}.
  - 0xC000: CTRL. [0]=flip_v, [1]=flip_h, [2]=cursor_en.
  - 0xC004: CURSOR. [6:0]=col, [22:16]=row.
  - Any other address: write ignored, read returns 0, still acked.
- Bus FSM: IDLE -> (stb & we) -> ACK, write committed on the IDLE->ACK edge.
  - IDLE -> (stb & !we) -> RD_WAIT -> ACK.
  - ACK: w_ack=1 for exactly one cycle -> IDLE.
  - Write latency is 1 cycle; read latency is 2 cycles.
  - A stb still high in the cycle after ACK starts a new transaction.
  - rst_n low mid-transaction returns the FSM to IDLE with no ack.
- Pixel pipeline: 4 cycles from x/y to r/g/b.
  - S0: rx = flip_h ? H_RES-1-x : x; ry = flip_v ? V_RES-1-y : y. Registered, together with a valid flag (x<H_RES && y<V_RES).
  - S1: VRAM port B read at (ry/GLYPH_H)*COLS + rx/GLYPH_W. Cell column/row and the pixel offset within the cell are registered.
  - S2: glyph_addr = {char, ry%GLYPH_H}.
  - S3: bit = glyph_data[GLYPH_W-1-(rx%GLYPH_W)]. If the cursor is on this cell and cursor_en & blink phase, fg and bg are swapped. Output {r,g,b} = palette[bit ? fg : bg].
  - Invalid pixel (out of range) outputs 0 regardless of VRAM contents.
- Bus writes to VRAM or palette become visible to the pixel path from the cycle after ACK; no tearing protection.
- Simultaneous bus access and pixel read of the same cell: port A (bus) write wins; port B returns the old data that cycle.
- Blink: frame start is detected when (x,y) transitions to (0,0). The counter increments per frame; when it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles. Writing CTRL with cursor_en=1 clears the counter and sets the phase to 1.
- Cursor position out of range (col>=COLS or row>=ROWS): no cursor drawn.

Test Plan:
- Reset then write VRAM cell 0 = 0x0F41, palette15=0xFFF, palette0=0x000; glyph ROM row 0 of 'A' = 0x80; scan (0,0) with flip_v=0 -> glyph_addr={0x41,0} at S2; r/g/b=F,F,F 4 cycles after x=0; pixel (1,0) -> 0,0,0.
- Read-back: write 0x1234 to 0x0004, then read 0x0004 -> w_ack exactly 2 cycles after stb, w_dat_o=0x00001234. Read 0xF000 -> ack with 0. Write latency is 1 cycle.
- Flip: flip_v=1, flip_h=1; scan (799,479) -> VRAM address 0 and pixel offset 0; r/g/b matches the unflipped (0,0) result.
- Cursor: CURSOR=(col 0,row 0), cursor_en=1 -> cell 0 colours inverted. After 30 frame starts, normal colours. After 60 frame starts, inverted again.
- Out-of-range: x=800 or y=480 -> r/g/b=0 after 4 cycles. Cursor col=100 -> no inversion anywhere.
- Async reset: assert rst_n during RD_WAIT -> w_ack never pulses, outputs 0 immediately. After release, CTRL reads back 0x1 and palette5 reads 0x555.
